tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Programmable tick-rate controller for the LED counter datapath. It generates a 50 % duty square clock-enable (`clk_out`) and a one-cycle `tick` pulse at a runtime-selectable rate. A 2-input round-robin arbiter accepts rate-change requests from two requesters, for example a button stepper and a host interface. Each accepted rate change is applied only at a half-period boundary, so the output never glitches.

## Interface
- `HP_W`, 27: width of the half-period terminal count; covers 100 MHz down to 1 Hz.
- `DEFAULT_HP`, 27'd49_999_999: half-period count loaded at reset (1 Hz at 100 MHz).

- `clk_in`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  run/pause control; high = RUN.
- `req_valid`  in  2  per-requester rate-change valid.
- `req0_hp`  in  HP_W  requester 0 half-period terminal count.
- `req1_hp`  in  HP_W  requester 1 half-period terminal count.
- `req_ready`  out  2  per-requester accept; a transfer occurs when valid&ready.
- `clk_out`  out  1  divided square output; half period = active_hp+1 cycles.
- `tick`  out  1  one-cycle pulse, registered, coincident with each 0->1 of `clk_out`.
- `active_hp`  out  HP_W  half-period count currently in use.
- `pending`  out  1  an accepted request is waiting to be applied.

## Operation
- Reset (`reset`=0 at a clock edge):
  - state=STOP, `count`=0, `clk_out`=0, `tick`=0.
  - `active_hp`=DEFAULT_HP, `pending`=0, RR pointer favours requester 0.
- FSM:
  - STOP -> RUN when `en`=1.
  - RUN -> STOP when `en`=0.
  - On entering STOP: `count` clears to 0, `clk_out` holds its level, no ticks.
- RUN counting:
  - Below `active_hp`: `count` increments.
  - At `count`==`active_hp`: `count`<=0 and `clk_out` toggles. `tick`<=1 only if `clk_out` goes 0->1; otherwise `tick`=0.
- Half-period value N gives a half period of N+1 cycles. N=0 is legal and toggles every cycle.
- Arbitration and request acceptance:
  - `req_ready` is combinational and one-hot or zero.
  - It asserts only when `pending`=0 and the requester is valid.
  - If both requesters are valid, the RR pointer picks the winner. After a grant, the pointer moves to the other requester.
  - An accepted value is stored in the pending register and sets `pending`=1.
  - While `pending`=1, `req_ready`=0 for both requesters.
- Applying a pending value:
  - In RUN: applied in the boundary cycle only (`count`==`active_hp`). Effects: `active_hp`<=pending value, `pending`<=0, `count`<=0, and the toggle still occurs. The new rate governs the next half period.
  - In STOP: applied on the next edge; `count` stays 0.
- No accept and apply in the same cycle: `ready` depends on the registered `pending`, so a freed slot accepts on the following cycle at the earliest.
- Reset mid-operation discards `pending` and restores all reset values on that edge.
- Each requester's value is taken only on transfer. Holding `req_valid` high after transfer requests a second change.

## Timing
- `en` 0->1 sampled at edge E0 -> RUN from E0, `count`=0. The first `clk_out` toggle (0->1, `tick`) occurs at edge E0+N+1. After that, the period is 2(N+1) cycles and ticks are 2(N+1) apart.
- Request-to-visible-change latency:
  - One cycle to pending.
  - In RUN, up to N_old+1 further cycles.
  - In STOP, one further cycle.
- `en` 1->0 at edge E -> STOP at E. `clk_out` is frozen and `tick`=0 from E.
- All outputs are registered except `req_ready`.

## Structure
- Package `tick_sched_pkg`:
  - `state_t` enum (STOP, RUN).
  - `HP_W`, `DEFAULT_HP`, `CLK_HZ`=100_000_000.
- Sub-module `rr_arbiter2`:
  - Inputs: `clk_in`, `reset`, `req[1:0]`, `advance` (= transfer).
  - Output: one-hot `grant[1:0]`.
  - Contains the pointer flop.
- The top level holds the FSM, counter, pending register, and output flops.

## Test plan
- Reset with `en`=0 -> `clk_out`=0, `tick`=0, `active_hp`=49_999_999, `pending`=0, `req_ready`=00 with no valids.
- Set `req0_hp`=3, let it apply in STOP, then `en`=1 at E0 -> first `tick` at E0+4. Then `tick` every 8 cycles and `clk_out` high 4 cycles / low 4 cycles.
- Both valid simultaneously (hp 3 vs 1) at reset pointer -> req0 granted first with `req_ready`=01. Req1 is granted only on the cycle after req0's value applies. Next simultaneous request -> req0 granted (pointer alternated).
- In RUN with hp=3, request hp=1 at `count`=1 -> `pending`=1 until the boundary. The current half period completes in 4 cycles, then half periods are 2 cycles.
- Drop `en` at `count`=2 with `clk_out`=1 -> `clk_out` stays 1 and no ticks. A request accepted during STOP applies the next cycle. Re-enable -> first toggle (1->0, no tick) after N+1 cycles.
- Assert `reset` mid-RUN with `pending`=1 -> all reset values next edge and the pending value is lost.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared constants and state encoding for the tick scheduler.
package tick_sched_pkg;

    // Half-period terminal count width: covers 100 MHz down to 1 Hz.
    localparam int unsigned HP_W = 27;
    // 1 Hz output at the nominal system clock.
    localparam logic [HP_W-1:0] DEFAULT_HP = 27'd49_999_999;
    localparam int unsigned CLK_HZ = 100_000_000;

    // FSM encoding kept as plain constants for compatibility with older tools.
    typedef logic [0:0] state_t;
    localparam state_t STOP = 1'b0;
    localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer flips to the loser after each grant.
module rr_arbiter2 (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0 favours requester 0, 1 favours requester 1.
    logic ptr_q;

    // One-hot (or zero) grant; the pointer only matters when both request.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Move priority to the requester that did not win.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable square clock-enable / tick generator with glitch-free rate changes.
module tick_scheduler
    import tick_sched_pkg::*;
(
    input  logic            clk_in,
    input  logic            reset,
    input  logic            en,
    input  logic [1:0]      req_valid,
    input  logic [HP_W-1:0] req0_hp,
    input  logic [HP_W-1:0] req1_hp,
    output logic [1:0]      req_ready,
    output logic            clk_out,
    output logic            tick,
    output logic [HP_W-1:0] active_hp,
    output logic            pending
);

    state_t          state_q, state_d;
    logic [HP_W-1:0] count_q, count_d;
    logic            clk_out_q, clk_out_d;
    logic            tick_q, tick_d;
    logic [HP_W-1:0] active_hp_q, active_hp_d;
    logic            pending_q, pending_d;
    logic [HP_W-1:0] pend_hp_q, pend_hp_d;

    logic [1:0] arb_req;
    logic [1:0] grant;
    logic       transfer;

    // A full pending slot masks both requesters, so accept and apply never coincide.
    assign arb_req  = pending_q ? 2'b00 : req_valid;
    assign transfer = |grant;

    rr_arbiter2 u_arb (
        .clk_in  (clk_in),
        .reset   (reset),
        .req     (arb_req),
        .advance (transfer),
        .grant   (grant)
    );

    // Next-state: request capture, run/stop control, counting and rate apply.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        clk_out_d   = clk_out_q;
        tick_d      = 1'b0;
        active_hp_d = active_hp_q;
        pending_d   = pending_q;
        pend_hp_d   = pend_hp_q;

        if (transfer) begin
            pending_d = 1'b1;
            pend_hp_d = grant[1] ? req1_hp : req0_hp;
        end

        case (state_q)
            RUN: begin
                if (!en) begin
                    // Freeze the output level; the half period restarts on re-enable.
                    state_d = STOP;
                    count_d = '0;
                end else if (count_q == active_hp_q) begin
                    count_d   = '0;
                    clk_out_d = ~clk_out_q;
                    tick_d    = ~clk_out_q;
                    if (pending_q) begin
                        active_hp_d = pend_hp_q;
                        pending_d   = 1'b0;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                count_d = '0;
                if (pending_q) begin
                    active_hp_d = pend_hp_q;
                    pending_d   = 1'b0;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= STOP;
            count_q     <= '0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            active_hp_q <= DEFAULT_HP;
            pending_q   <= 1'b0;
            pend_hp_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            active_hp_q <= active_hp_d;
            pending_q   <= pending_d;
            pend_hp_q   <= pend_hp_d;
        end
    end

    assign req_ready = grant;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign active_hp = active_hp_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler; tick edges are predicted into a scoreboard queue.
module tb_tick_scheduler;
    import tick_sched_pkg::*;

    logic            clk_in;
    logic            reset;
    logic            en;
    logic [1:0]      req_valid;
    logic [HP_W-1:0] req0_hp;
    logic [HP_W-1:0] req1_hp;
    logic [1:0]      req_ready;
    logic            clk_out;
    logic            tick;
    logic [HP_W-1:0] active_hp;
    logic            pending;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tick_q[$];

    tick_scheduler dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req0_hp   (req0_hp),
        .req1_hp   (req1_hp),
        .req_ready (req_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .active_hp (active_hp),
        .pending   (pending)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Edge index of the most recent rising edge.
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance n edges; each edge pops/compares the tick scoreboard.
    task automatic step(input int n);
        logic exp_t;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            exp_t = (tick_q.size() > 0) && (tick_q[0] == cyc);
            if (exp_t) void'(tick_q.pop_front());
            check("tick", 32'(tick), 32'(exp_t));
        end
    endtask

    // Single-requester transfer: ready must be up before the edge, valid drops after.
    task automatic do_req(input int r, input logic [HP_W-1:0] hp);
        if (r == 0) begin
            req0_hp   = hp;
            req_valid = 2'b01;
        end else begin
            req1_hp   = hp;
            req_valid = 2'b10;
        end
        #1;
        check("req_ready_single", 32'(req_ready), 32'(req_valid));
        step(1);
        req_valid = 2'b00;
        #1;
    endtask

    initial begin
        int e;
        int k;
        reset     = 1'b0;
        en        = 1'b0;
        req_valid = 2'b00;
        req0_hp   = '0;
        req1_hp   = '0;

        // Reset values.
        step(2);
        check("rst_clk_out", 32'(clk_out), 32'(0));
        check("rst_active_hp", 32'(active_hp), 32'd49_999_999);
        check("rst_pending", 32'(pending), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        reset = 1'b1;
        step(1);

        // Load hp=3 while stopped, then run: ticks every 8 cycles, 4 high / 4 low.
        do_req(0, 27'd3);
        check("stop_pending_set", 32'(pending), 32'(1));
        check("stop_ready_blocked", 32'(req_ready), 32'(0));
        step(1);
        check("stop_apply_hp", 32'(active_hp), 32'(3));
        check("stop_apply_pending", 32'(pending), 32'(0));
        en = 1'b1;
        e  = cyc + 1;
        tick_q.push_back(e + 4);
        tick_q.push_back(e + 12);
        tick_q.push_back(e + 20);
        for (int i = 0; i < 21; i++) begin
            step(1);
            k = cyc - e;
            check("run3_clk_out", 32'(clk_out), 32'((k >= 4) && (((k - 4) / 4) % 2 == 0)));
        end

        // Drop en at count=2 with clk_out=1: level frozen, no ticks.
        step(2);
        en = 1'b0;
        step(1);
        check("pause_clk_out", 32'(clk_out), 32'(1));
        do_req(0, 27'd1);
        check("pause_pending_set", 32'(pending), 32'(1));
        step(1);
        check("pause_apply_hp", 32'(active_hp), 32'(1));
        check("pause_apply_pending", 32'(pending), 32'(0));
        step(3);
        check("pause_clk_hold", 32'(clk_out), 32'(1));
        // Re-enable with N=1: first toggle is 1->0 without a tick.
        en = 1'b1;
        e  = cyc + 1;
        tick_q.push_back(e + 4);
        tick_q.push_back(e + 8);
        for (int i = 0; i < 9; i++) begin
            step(1);
            k = cyc - e;
            check("resume_clk_out", 32'(clk_out),
                  32'((k < 2) ? 1 : (((k - 2) / 2) % 2 == 1)));
        end

        // Back to hp=3, then change to hp=1 mid half-period at count=1.
        en = 1'b0;
        step(1);
        do_req(0, 27'd3);
        step(1);
        check("reload_hp3", 32'(active_hp), 32'(3));
        en = 1'b1;
        e  = cyc + 1;
        step(2);
        do_req(0, 27'd1);
        check("midrun_pending_a", 32'(pending), 32'(1));
        step(1);
        check("midrun_pending_b", 32'(pending), 32'(1));
        check("midrun_hp_old", 32'(active_hp), 32'(3));
        tick_q.push_back(e + 6);
        tick_q.push_back(e + 10);
        for (int i = 0; i < 7; i++) begin
            step(1);
            k = cyc - e;
            if (k == 4) begin
                check("midrun_apply_hp", 32'(active_hp), 32'(1));
                check("midrun_apply_pending", 32'(pending), 32'(0));
            end
            check("midrun_clk_out", 32'(clk_out), 32'(((k - 4) / 2) % 2 == 1));
        end

        // Reset mid-RUN with a pending value: everything restored, value lost.
        do_req(0, 27'd5);
        check("rstrun_pending", 32'(pending), 32'(1));
        reset = 1'b0;
        en    = 1'b0;
        step(1);
        check("rstrun_clk_out", 32'(clk_out), 32'(0));
        check("rstrun_hp", 32'(active_hp), 32'd49_999_999);
        check("rstrun_pending_clr", 32'(pending), 32'(0));
        reset = 1'b1;
        step(3);
        check("rstrun_value_lost", 32'(active_hp), 32'd49_999_999);

        // Simultaneous requests from the reset pointer.
        req0_hp   = 27'd3;
        req1_hp   = 27'd1;
        req_valid = 2'b11;
        #1;
        check("arb_first_req0", 32'(req_ready), 32'(2'b01));
        step(1);
        check("arb_blocked", 32'(req_ready), 32'(0));
        step(1);
        check("arb_apply_req0", 32'(active_hp), 32'(3));
        check("arb_second_req1", 32'(req_ready), 32'(2'b10));
        step(1);
        check("arb_blocked2", 32'(req_ready), 32'(0));
        step(1);
        check("arb_apply_req1", 32'(active_hp), 32'(1));
        check("arb_third_req0", 32'(req_ready), 32'(2'b01));
        req_valid = 2'b00;
        step(2);

        check("tick_queue_drained", 32'(tick_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
